// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its load-extension helper.
package dmem_arbiter_pkg;

  // RV32 load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32 store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Requester indices
  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  localparam int NUM_PORTS = 2;

  // Width of the starvation counter (holds limits up to 15)
  localparam int STARVE_CW = 4;

  // Arbitration outcome for one cycle
  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_M0   = 2'd1,
    WIN_M1   = 2'd2
  } win_e;

  // Natural alignment check. The access size comes from funct3[1:0];
  // codes other than byte/half are treated as a word access.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arbiter_load_extend.sv
// Combinational load formatter: picks the byte/half/word out of a memory
// word, sign- or zero-extends it, and flags misaligned accesses.
module dmem_arbiter_load_extend
  import dmem_arbiter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection, extension and alignment check
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
    misaligned = is_misaligned(funct3, addr_lo);

    rdata = word;
    case (funct3)
      F3_LB:   rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  rdata = {24'h0, byte_sel};
      F3_LH:   rdata = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  rdata = {16'h0, half_sel};
      default: rdata = word;
    endcase
    // A misaligned access never returns data
    if (misaligned) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port 0 (CPU)
// normally wins; port 1 (loader/DMA) gains priority after waiting too long.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [31:0]   m0_wd,
  input  logic [2:0]    m0_funct3,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m1_wd,
  input  logic [2:0]    m1_funct3,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          m1_err,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic [2:0]    mem_funct3,
  input  logic [31:0]   mem_rd
);

  localparam logic [STARVE_CW-1:0] LIMIT_C = STARVE_CW'(STARVE_LIMIT);

  win_e                 win;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [31:0]          sel_wd;
  logic [2:0]           sel_f3;
  logic [31:0]          ext_rdata;
  logic                 misaligned;
  logic [31:0]          resp_data;
  logic [NUM_PORTS-1:0] gnt_vec;

  logic                 prio1_q, prio1_d;
  logic [STARVE_CW-1:0] starve_cnt_q, starve_cnt_d;

  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [31:0]          rdata_q [NUM_PORTS];
  logic [31:0]          rdata_d [NUM_PORTS];

  // Pick the winner; reset suppresses every grant
  always_comb begin
    win = WIN_NONE;
    if (!rst) begin
      if (prio1_q) begin
        if (m1_req)      win = WIN_M1;
        else if (m0_req) win = WIN_M0;
      end else begin
        if (m0_req)      win = WIN_M0;
        else if (m1_req) win = WIN_M1;
      end
    end
  end

  // Route the winner's request onto the memory side
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    sel_f3   = '0;
    case (win)
      WIN_M0: begin
        sel_we   = m0_we;
        sel_addr = m0_addr;
        sel_wd   = m0_wd;
        sel_f3   = m0_funct3;
      end
      WIN_M1: begin
        sel_we   = m1_we;
        sel_addr = m1_addr;
        sel_wd   = m1_wd;
        sel_f3   = m1_funct3;
      end
      default: ;
    endcase
  end

  dmem_arbiter_load_extend u_load_extend (
    .word       (mem_rd),
    .addr_lo    (sel_addr[1:0]),
    .funct3     (sel_f3),
    .rdata      (ext_rdata),
    .misaligned (misaligned)
  );

  assign gnt_vec[PORT_CPU] = (win == WIN_M0);
  assign gnt_vec[PORT_DMA] = (win == WIN_M1);
  assign m0_gnt     = gnt_vec[PORT_CPU];
  assign m1_gnt     = gnt_vec[PORT_DMA];

  // A misaligned store is granted and acknowledged but never written
  assign mem_we     = sel_we & ~misaligned;
  assign mem_addr   = sel_addr;
  assign mem_wd     = sel_wd;
  assign mem_funct3 = sel_f3;

  // Stores and misaligned accesses acknowledge with zero data
  assign resp_data  = (sel_we || misaligned) ? 32'h0 : ext_rdata;

  // Next response state: the granted port gets a one-cycle strobe
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_d[p] = 1'b0;
      err_d[p]    = err_q[p];
      rdata_d[p]  = rdata_q[p];
      if (gnt_vec[p]) begin
        rvalid_d[p] = 1'b1;
        err_d[p]    = misaligned;
        rdata_d[p]  = resp_data;
      end
    end
  end

  // Starvation tracking for port 1: count ungranted request cycles and
  // raise priority once the count has sat at the limit for a cycle
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    prio1_d      = prio1_q;
    if (m1_gnt || !m1_req) begin
      starve_cnt_d = '0;
      prio1_d      = 1'b0;
    end else if (starve_cnt_q == LIMIT_C) begin
      prio1_d      = 1'b1;
    end else begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q     <= '0;
      err_q        <= '0;
      starve_cnt_q <= '0;
      prio1_q      <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= '0;
      end
    end else begin
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      prio1_q      <= prio1_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        rdata_q[p] <= rdata_d[p];
      end
    end
  end

  assign m0_rvalid = rvalid_q[PORT_CPU];
  assign m0_err    = err_q[PORT_CPU];
  assign m0_rdata  = rdata_q[PORT_CPU];
  assign m1_rvalid = rvalid_q[PORT_DMA];
  assign m1_err    = err_q[PORT_DMA];
  assign m1_rdata  = rdata_q[PORT_DMA];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
  logic [2:0]  m0_funct3 = 0, m1_funct3 = 0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_funct3;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_funct3(m0_funct3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_funct3(m1_funct3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
    int size;
    logic [31:0] mask, v;
    size = acc_size(f3);
    if (size == 4) return w;
    mask = (32'd1 << (8 * size)) - 32'd1;
    v = (w >> (8 * int'(off))) & mask;
    if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [1:0] off,
                                              input logic [2:0] f3);
    int size;
    logic [31:0] mask;
    size = acc_size(f3);
    mask = (size == 4) ? 32'hFFFF_FFFF
                       : (((32'd1 << (8 * size)) - 32'd1) << (8 * int'(off)));
    return (old & ~mask) | ((wd << (8 * int'(off))) & mask);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- data memory (environment) ----------------
  logic [31:0] mem_arr [0:1023] = '{default: 32'h0};
  assign mem_rd = mem_arr[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we)
      mem_arr[mem_addr[11:2]] <= store_merge(mem_arr[mem_addr[11:2]], mem_wd,
                                             mem_addr[1:0], mem_funct3);
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] sh_mem [0:1023] = '{default: 32'h0};
  int          waited = 0;          // consecutive ungranted m1 request cycles
  logic [1:0]  exp_rv = 2'b00;
  logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
  logic [1:0]  exp_err = 2'b00;

  always @(negedge clk) begin : model
    int win;
    logic prio, we, mis;
    logic [31:0] a, wd;
    logic [2:0] f3;
    if (chk_en) begin
      prio = (waited > LIMIT);
      win = -1;
      if (!rst) begin
        if (prio) win = m1_req ? 1 : (m0_req ? 0 : -1);
        else      win = m0_req ? 0 : (m1_req ? 1 : -1);
      end
      we = 0; a = 0; wd = 0; f3 = 0;
      if (win == 0) begin we = m0_we; a = m0_addr; wd = m0_wd; f3 = m0_funct3; end
      if (win == 1) begin we = m1_we; a = m1_addr; wd = m1_wd; f3 = m1_funct3; end
      mis = (win >= 0) && ((int'(a[1:0]) % acc_size(f3)) != 0);

      chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));
      chk("mem_we", 32'(mem_we), 32'(we && !mis));
      chk("mem_addr", mem_addr, a);
      chk("mem_wd", mem_wd, wd);
      chk("mem_funct3", 32'(mem_funct3), 32'(f3));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
      if (exp_rv[0]) begin
        chk("m0_rdata", m0_rdata, exp_rd[0]);
        chk("m0_err", 32'(m0_err), 32'(exp_err[0]));
      end
      if (exp_rv[1]) begin
        chk("m1_rdata", m1_rdata, exp_rd[1]);
        chk("m1_err", 32'(m1_err), 32'(exp_err[1]));
      end

      // advance the model to the next cycle
      exp_rv = 2'b00;
      if (win >= 0) begin
        exp_rv[win]  = 1'b1;
        exp_err[win] = mis;
        exp_rd[win]  = (we || mis) ? 32'h0 : load_val(sh_mem[a[11:2]], a[1:0], f3);
        if (we && !mis) sh_mem[a[11:2]] = store_merge(sh_mem[a[11:2]], wd, a[1:0], f3);
      end
      if (rst) waited = 0;
      else if (m1_req && win != 1) waited++;
      else waited = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f);
    m0_req = r; m0_we = w; m0_addr = a; m0_wd = d; m0_funct3 = f;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f);
    m1_req = r; m1_we = w; m1_addr = a; m1_wd = d; m1_funct3 = f;
  endtask

  task automatic rnd_req(output logic r, output logic w, output logic [31:0] a,
                         output logic [31:0] d, output logic [2:0] f);
    r = ($urandom_range(0, 9) < 6);
    w = $urandom_range(0, 1) == 1;
    a = 32'($urandom_range(0, 255));
    d = $urandom;
    f = 3'($urandom_range(0, 7));
  endtask

  logic [31:0] ld_addr [4] = '{32'h23, 32'h23, 32'h22, 32'h22};
  logic [2:0]  ld_f3   [4] = '{LB, LBU, LH, LHU};
  logic [31:0] ld_exp  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF};
  logic        st_pat  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin : stim
    logic g0, g1, r, w;
    logic [31:0] a, d;
    logic [2:0] f;

    // reset
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    cyc();
    rst = 1'b0;

    // store then load back a word
    drv0(1, 1, 32'h10, 32'hDEADBEEF, SW);
    @(negedge clk); chk("d1_sw_gnt", 32'(m0_gnt), 32'h1);
    cyc();
    drv0(1, 0, 32'h10, 32'h0, LW);
    @(negedge clk);
    chk("d1_lw_gnt", 32'(m0_gnt), 32'h1);
    chk("d1_sw_ack", 32'(m0_rvalid), 32'h1);
    chk("d1_sw_rdata", m0_rdata, 32'h0);
    cyc();
    drv0(0, 0, 32'h0, 32'h0, 3'h0);
    @(negedge clk);
    chk("d1_lw_rvalid", 32'(m0_rvalid), 32'h1);
    chk("d1_lw_rdata", m0_rdata, 32'hDEADBEEF);
    chk("d1_lw_err", 32'(m0_err), 32'h0);
    cyc();

    // sub-word load extension
    drv0(1, 1, 32'h20, 32'h80FF7F01, SW);
    cyc();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drv0(1, 0, ld_addr[i], 32'h0, ld_f3[i]);
      else       drv0(0, 0, 32'h0, 32'h0, 3'h0);
      @(negedge clk);
      if (i > 0) begin
        chk("d2_ext_rvalid", 32'(m0_rvalid), 32'h1);
        chk("d2_ext_rdata", m0_rdata, ld_exp[i - 1]);
      end
      cyc();
    end

    // starvation: both ports requesting continuously
    drv0(1, 0, 32'h20, 32'h0, LW);
    drv1(1, 0, 32'h10, 32'h0, LW);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("d3_m0_gnt", 32'(m0_gnt), 32'(st_pat[i]));
      chk("d3_m1_gnt", 32'(m1_gnt), 32'(!st_pat[i]));
      cyc();
    end
    drv0(0, 0, 32'h0, 32'h0, 3'h0);
    drv1(0, 0, 32'h0, 32'h0, 3'h0);
    cyc();

    // misaligned halfword store from port 1
    drv1(1, 1, 32'h31, 32'h1234, SH);
    @(negedge clk);
    chk("d4_gnt", 32'(m1_gnt), 32'h1);
    chk("d4_mem_we", 32'(mem_we), 32'h0);
    cyc();
    drv1(0, 0, 32'h0, 32'h0, 3'h0);
    @(negedge clk);
    chk("d4_rvalid", 32'(m1_rvalid), 32'h1);
    chk("d4_err", 32'(m1_err), 32'h1);
    chk("d4_rdata", m1_rdata, 32'h0);
    chk("d4_mem_word", mem_arr[12], 32'h0);
    cyc();

    // reset during a store grant cycle
    drv0(1, 1, 32'h50, 32'h12345678, SW);
    rst = 1'b1;
    @(negedge clk);
    chk("d5_gnt", 32'(m0_gnt), 32'h0);
    chk("d5_mem_we", 32'(mem_we), 32'h0);
    chk("d5_mem_addr", mem_addr, 32'h0);
    cyc();
    rst = 1'b0;
    drv0(0, 0, 32'h0, 32'h0, 3'h0);
    @(negedge clk);
    chk("d5_rvalid", 32'(m0_rvalid), 32'h0);
    chk("d5_mem_word", mem_arr[20], 32'h0);
    cyc();

    // byte store then load from the other port, back to back
    drv0(1, 1, 32'h41, 32'hAA, SB);
    cyc();
    drv0(0, 0, 32'h0, 32'h0, 3'h0);
    drv1(1, 0, 32'h40, 32'h0, LW);
    @(negedge clk);
    chk("d6_m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("d6_m1_gnt", 32'(m1_gnt), 32'h1);
    cyc();
    drv1(0, 0, 32'h0, 32'h0, 3'h0);
    @(negedge clk);
    chk("d6_m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("d6_m1_rdata", m1_rdata, 32'h0000AA00);
    chk("d6_m0_rvalid_off", 32'(m0_rvalid), 32'h0);
    cyc();

    // random traffic honouring the hold-until-grant contract
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g0 = m0_gnt;
      g1 = m1_gnt;
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      if (m0_req && !g0) begin
        if ($urandom_range(0, 9) == 0) m0_req = 1'b0;
      end else begin
        rnd_req(r, w, a, d, f);
        drv0(r, w, a, d, f);
      end
      if (m1_req && !g1) begin
        if ($urandom_range(0, 9) == 0) m1_req = 1'b0;
      end else begin
        rnd_req(r, w, a, d, f);
        drv1(r, w, a, d, f);
      end
    end
    rst = 1'b0;
    drv0(0, 0, 32'h0, 32'h0, 3'h0);
    drv1(0, 0, 32'h0, 32'h0, 3'h0);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store path) and port 1 (program loader / debug DMA).
- Arbitrates one access per cycle and drives the memory's write-enable, address, write-data and funct3 inputs.
- Returns a registered, sign/zero-extended load result with a response strobe.
- Enforces natural alignment per access size.
- Port 0 has priority by default; a starvation counter guarantees port 1 progress.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles port 1 may request without a grant before it gets priority. Legal range 1..15.
- AW, 32: address width presented by requesters and driven to memory.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  port 0 request; held until m0_gnt
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  AW  port 0 byte address
- m0_wd  in  32  port 0 store data (low bits used for sb/sh)
- m0_funct3  in  3  RV32 load/store funct3
- m0_gnt  out  1  port 0 granted this cycle (combinational)
- m0_rvalid  out  1  port 0 response valid (one cycle after grant)
- m0_rdata  out  32  port 0 extended load data
- m0_err  out  1  port 0 misaligned access, qualified by m0_rvalid
- m1_req, m1_we, m1_addr, m1_wd, m1_funct3, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1
- mem_we  out  1  write enable to data memory
- mem_addr  out  AW  address to data memory
- mem_wd  out  32  store data to data memory
- mem_funct3  out  3  store width to data memory
- mem_rd  in  32  asynchronous read word from data memory (word at mem_addr[11:2])

Behaviour:
- Reset (rst=1 at a clock edge):
  - m*_rvalid, m*_rdata, m*_err, starvation counter and prio1 flag all clear to 0.
  - While rst=1: m*_gnt=0, mem_we=0, mem_addr/mem_wd/mem_funct3=0.
- Arbitration (combinational, same cycle):
  - prio1=0: m0_req wins; otherwise m1_req.
  - prio1=1: m1_req wins; otherwise m0_req.
  - At most one gnt per cycle. No request: mem_we=0, mem outputs 0.
- Mux: the winner's addr/wd/funct3 drive mem_*. mem_we = winner_we AND NOT misaligned.
- Store commit: the memory writes on the same edge the grant is sampled. The store has completed when gnt is seen.
- Response:
  - On the edge ending a grant cycle, register winner rvalid=1, err, and rdata. Latency is exactly 1 cycle.
  - rvalid is a single-cycle pulse.
  - Back-to-back grants allowed, giving back-to-back rvalid.
  - For stores, rdata=0 and rvalid=1 (acknowledge).
- Load extension (word = mem_rd, b = addr[1:0]):
  - lb (000): sign-extend byte b.
  - lbu (100): zero-extend byte b.
  - lh (001): sign-extend half addr[1].
  - lhu (101): zero-extend half addr[1].
  - lw (010): full word.
  - Other funct3 codes: treated as lw.
- Misalignment:
  - half access with addr[0]=1, or word access with addr[1:0]!=0, sets err=1.
  - No write occurs; rdata=0; still granted and still acknowledged.
- Starvation counter:
  - Increments each cycle m1_req=1 and m1_gnt=0, saturating at STARVE_LIMIT.
  - When it equals STARVE_LIMIT, prio1 is set on the next edge.
  - On m1_gnt, counter and prio1 clear on that edge.
  - If m1_req drops without a grant, counter clears.
- Simultaneous rst and request: reset wins; no write, no response.
- Requester contract: inputs stable while req=1 and gnt=0. Dropping req before gnt is legal and the request is abandoned.

Decomposition:
- Shared package holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - port index constants.
  - the 4-bit width of the starvation counter.
- One natural sub-module, load_extend: combinational. Inputs word, addr[1:0] and funct3; outputs rdata and misaligned. Also reused by the core's writeback path.

Test Plan:
- Only m0_req, sw addr 0x10 wd 0xDEADBEEF, then m0 lw 0x10 -> m0_gnt each cycle; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m0_err=0.
- Word 0x80FF7F01 at 0x20; lb 0x23, lbu 0x23, lh 0x22, lhu 0x22 -> rdata 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- m0_req and m1_req held continuously with STARVE_LIMIT=4 -> m0 granted 5 cycles, then m1 granted once, then m0 again. Counter cleared after the m1 grant.
- m1 sh at 0x31 -> m1_gnt=1, mem_we=0, memory unchanged; next cycle m1_rvalid=1, m1_err=1, m1_rdata=0.
- rst asserted in the grant cycle of an m0 sw -> mem_we=0, no m0_rvalid next cycle, memory word unchanged, all outputs 0.
- m0 sb 0x41 wd 0xAA, then m1 lw 0x40 on the next cycle -> m1_rdata=0x0000AA00 with rvalid on consecutive cycles for m0 then m1.
